fetch_queue_unit: RTL

//  Sequential successor to the combinational field splitter: owns the PC, issues instruction-memory

---
 rtl/fetch_queue_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_queue_unit.sv
// Owns the PC, issues credit-limited imem reads and buffers responses in a DEPTH-entry FWFT queue with split fields.
// Response to out_valid takes 1 cycle; requests stall once buffered+in-flight reaches DEPTH, so responses never need backpressure.
module fetch_queue_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [4:0]      A1,
  output logic [4:0]      A2,
  output logic [4:0]      A3,
  output logic [6:0]      OP,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [24:0]     Imm
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [31:0]     q_instr [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW:0]     credits_used;
  logic [XLEN-1:0] redir_pc;
  logic            req_fire;
  logic            resp_take;
  logic            push;
  logic            pop;
  logic            unused_redirect_lsb;

  assign redir_pc            = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit rule: buffered + in-flight words never exceed the queue size.
  assign credits_used   = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = rst_n && !redirect_valid && (credits_used < DEPTH[CW:0]);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_take = imem_resp_valid && (outstanding != '0);
  assign push      = resp_take && (drop_cnt == '0) && !redirect_valid;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Everything still owed by memory belongs to the old path and is discarded.
      fetch_pc    <= redir_pc;
      resp_pc     <= redir_pc;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding - CW'(resp_take);
      drop_cnt    <= outstanding - CW'(resp_take);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
      if (resp_take && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      if (push) begin
        resp_pc <= resp_pc + XLEN'(4);
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= resp_pc;
      q_instr[wr_ptr] <= imem_resp_data;
    end
  end

  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    if (out_valid) begin
      out_pc    = q_pc[rd_ptr];
      out_instr = q_instr[rd_ptr];
    end
  end

  assign OP     = out_instr[6:0];
  assign A3     = out_instr[11:7];
  assign funct3 = out_instr[14:12];
  assign A1     = out_instr[19:15];
  assign A2     = out_instr[24:20];
  assign funct7 = out_instr[31:25];
  assign Imm    = out_instr[31:7];

  resp_needs_credit: assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> (outstanding != '0));

endmodule
